c_matrix_readback_streamer: RTL and testbench

Downstream drain stage for matrix_multiplication. After a matmul finishes, it takes over the C-matrix read path and issues row addresses through enable_reading_from_mem/addr_pi. It captures the ORed data_from_out_mat rows after a fixed pipeline latency and streams them out on a valid/ready interface. Stalls are absorbed by a credit-limited FIFO, so no returning row is ever dropped.

---
 rtl/c_matrix_readback_streamer.sv | 140 ++++++++++++++
 tb/tb_c_matrix_readback_streamer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c_matrix_readback_streamer.sv
// Drains the C matrix out of matrix_multiplication row by row and streams it on valid/ready.
// Reads are only issued against free FIFO credit, so a returning row always has a slot.
module c_matrix_readback_streamer #(
  parameter int unsigned DWIDTH          = 8,
  parameter int unsigned BB_MAT_MUL_SIZE = 16,
  parameter int unsigned AWIDTH          = 7,
  parameter int unsigned NUM_ROWS        = 32,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                enable_reading_from_mem,
  output logic [AWIDTH-1:0]                   addr_pi,
  output logic                                addr_valid_dbg,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   data_from_out_mat,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]   m_data,
  output logic [AWIDTH-1:0]                   m_row_idx,
  output logic                                m_last
);

  localparam int unsigned W    = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IfW  = $clog2(READ_LATENCY + 1);
  localparam int unsigned SumW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

  localparam logic [AWIDTH:0]   LastCnt = (AWIDTH + 1)'(NUM_ROWS - 1);
  localparam logic [AWIDTH-1:0] LastIdx = AWIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                  state;
  // One bit wider than the address so NUM_ROWS == 2^AWIDTH terminates cleanly.
  logic [AWIDTH:0]         issue_cnt;
  logic [AWIDTH-1:0]       return_cnt;
  logic [AWIDTH-1:0]       last_addr;
  logic [READ_LATENCY-1:0] flight_sr;

  logic [W-1:0]            mem_data [FIFO_DEPTH];
  logic [AWIDTH-1:0]       mem_idx  [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr, rd_ptr;
  logic [CntW-1:0]         fifo_count;

  logic [IfW-1:0]          in_flight;
  logic                    issue, push, pop, fifo_full;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + IfW'(flight_sr[i]);
    end
  end

  // Credit: every outstanding read plus every buffered row owns one FIFO slot.
  assign issue = (state == StIssue) &&
                 ((SumW'(in_flight) + SumW'(fifo_count)) < SumW'(FIFO_DEPTH));
  assign push      = flight_sr[READ_LATENCY-1];
  assign m_valid   = (fifo_count != '0);
  assign pop       = m_valid && m_ready;
  assign fifo_full = (fifo_count == CntW'(FIFO_DEPTH));

  assign addr_valid_dbg          = issue;
  assign addr_pi                 = issue ? issue_cnt[AWIDTH-1:0] : last_addr;
  assign busy                    = (state == StIssue) || (state == StDrain);
  assign done                    = (state == StDone);
  assign enable_reading_from_mem = (state != StIdle);

  assign m_data    = m_valid ? mem_data[rd_ptr] : '0;
  assign m_row_idx = m_valid ? mem_idx[rd_ptr] : '0;
  assign m_last    = m_valid && (m_row_idx == LastIdx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      issue_cnt  <= '0;
      return_cnt <= '0;
      last_addr  <= '0;
      flight_sr  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StIssue;
            issue_cnt  <= '0;
            return_cnt <= '0;
          end
        end
        StIssue: begin
          if (issue && (issue_cnt == LastCnt)) state <= StDrain;
        end
        StDrain: begin
          if (pop && m_last) state <= StDone;
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase

      if (issue) begin
        issue_cnt <= issue_cnt + (AWIDTH + 1)'(1);
        last_addr <= issue_cnt[AWIDTH-1:0];
      end

      flight_sr <= {flight_sr[READ_LATENCY-2:0], issue};

      if (push) begin
        wr_ptr     <= (wr_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PtrW'(1);
        return_cnt <= return_cnt + AWIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PtrW'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CntW'(1);
        2'b01:   fifo_count <= fifo_count - CntW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Row storage carries no reset; visibility is gated by fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= data_from_out_mat;
      mem_idx[wr_ptr]  <= return_cnt;
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_c_matrix_readback_streamer.sv
// Bench for c_matrix_readback_streamer: models the C BRAM read pipeline and checks the drained
// row stream against the expected ascending row sequence.
module tb_c_matrix_readback_streamer;

  localparam int DW = 8;
  localparam int BB = 16;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int RL = 4;
  localparam int FD = 8;
  localparam int W  = DW * BB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          m_ready;
  logic          busy, done, enable_reading_from_mem, addr_valid_dbg, m_valid, m_last;
  logic [AW-1:0] addr_pi, m_row_idx;
  logic [W-1:0]  data_from_out_mat, m_data;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  c_matrix_readback_streamer #(
    .DWIDTH(DW), .BB_MAT_MUL_SIZE(BB), .AWIDTH(AW), .NUM_ROWS(NR),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .enable_reading_from_mem(enable_reading_from_mem), .addr_pi(addr_pi),
    .addr_valid_dbg(addr_valid_dbg), .data_from_out_mat(data_from_out_mat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row_idx(m_row_idx),
    .m_last(m_last)
  );

  // Upstream C read path: row r comes back as {16{r}} READ_LATENCY cycles after its address.
  logic [AW-1:0] up_addr [RL] = '{default: '0};
  logic          up_vld  [RL] = '{default: 1'b0};
  always @(posedge clk) begin
    up_addr[0] <= addr_pi;
    up_vld[0]  <= addr_valid_dbg && enable_reading_from_mem;
    for (int i = 1; i < RL; i++) begin
      up_addr[i] <= up_addr[i-1];
      up_vld[i]  <= up_vld[i-1];
    end
  end
  always_comb data_from_out_mat = up_vld[RL-1] ? {BB{8'(up_addr[RL-1])}} : {BB{8'hA5}};

  function automatic logic [W-1:0] row_model(input int r);
    logic [7:0] b;
    b = r[7:0];
    return {BB{b}};
  endfunction

  // Observations of one drain
  int           q_idx[$];
  logic [W-1:0] q_dat[$];
  logic         q_last[$];
  int           q_k[$];
  int           iss[$];
  int           first_valid_k, done_k, done_cnt, max_out, hold_viol, busy_low, stall_iss;
  int           stall_idx;
  logic [W-1:0] stall_data;
  logic         busy_at_done, en_at_done, post_busy, post_issue, timed_out;

  // Pulses start, then records one sample per cycle (#1 after each edge; k=0 is the accept edge).
  task automatic collect(input int ready_pct, input int stall, input int xs_a, input int xs_b,
                         input int stop_rows, input bit start_in_done, input int budget);
    int k, popped;
    bit fin, prev_stall;
    logic [W-1:0] prev_d;
    logic [AW-1:0] prev_i;
    q_idx.delete(); q_dat.delete(); q_last.delete(); q_k.delete(); iss.delete();
    first_valid_k = -1; done_k = -1; done_cnt = 0; max_out = 0; hold_viol = 0; busy_low = 0;
    stall_iss = -1; stall_idx = -1; stall_data = '0;
    busy_at_done = 1'bx; en_at_done = 1'bx; post_busy = 1'bx; post_issue = 1'bx; timed_out = 0;
    popped = 0; prev_stall = 0; prev_d = '0; prev_i = '0; fin = 0; k = -1;
    start = 1'b1;
    while (!fin) begin
      @(posedge clk); #1;
      k++;
      start = (k == xs_a || k == xs_b);
      m_ready = (k < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (stall > 0 && k == stall) begin
        stall_iss = iss.size(); stall_data = m_data; stall_idx = int'(m_row_idx);
      end
      if (addr_valid_dbg) iss.push_back(int'(addr_pi));
      if (first_valid_k < 0 && m_valid) first_valid_k = k;
      if (prev_stall && (!m_valid || m_data !== prev_d || m_row_idx !== prev_i)) hold_viol++;
      prev_stall = m_valid && !m_ready; prev_d = m_data; prev_i = m_row_idx;
      if (iss.size() - popped > max_out) max_out = iss.size() - popped;
      if (done_k < 0 && !done && busy !== 1'b1) busy_low++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k; busy_at_done = busy; en_at_done = enable_reading_from_mem;
          if (start_in_done) start = 1'b1;
        end
      end
      if (m_valid && m_ready) begin
        q_idx.push_back(int'(m_row_idx)); q_dat.push_back(m_data);
        q_last.push_back(m_last); q_k.push_back(k);
        popped++;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        post_busy = busy; post_issue = addr_valid_dbg; fin = 1;
      end
      if (stop_rows > 0 && popped == stop_rows) fin = 1;
      if (k >= budget) begin timed_out = 1; fin = 1; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, enable_reading_from_mem, addr_valid_dbg, m_valid, m_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, enable_reading_from_mem, addr_valid_dbg, m_valid, m_last});
    end
    n_cmp++;
    if (addr_pi !== '0 || m_row_idx !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h idx=%h data=%h want 0", addr_pi, m_row_idx, m_data);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, enable_reading_from_mem, m_valid, addr_valid_dbg} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 0000",
               {busy, enable_reading_from_mem, m_valid, addr_valid_dbg});
    end
  endtask

  task automatic test_basic();
    collect(100, 0, -1, -1, 0, 0, 400);
    n_cmp++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got timeout want done"); end
    n_cmp++;
    if (first_valid_k != RL + 1) begin
      n_fail++; $display("FAIL basic_first_valid: got %0d want %0d", first_valid_k, RL + 1);
    end
    n_cmp++;
    if (q_idx.size() != NR) begin
      n_fail++; $display("FAIL basic_rows: got %0d want %0d", q_idx.size(), NR);
    end
    for (int r = 0; r < NR; r++) begin
      n_cmp++;
      if (r >= q_idx.size() || q_idx[r] != r || q_dat[r] !== row_model(r) ||
          q_last[r] !== (r == NR - 1) || q_k[r] != RL + 1 + r) begin
        n_fail++;
        $display("FAIL basic_row%0d: got idx=%0d last=%b k=%0d data=%h want idx=%0d last=%b k=%0d",
                 r, (r < q_idx.size()) ? q_idx[r] : -1, (r < q_idx.size()) ? q_last[r] : 1'bx,
                 (r < q_idx.size()) ? q_k[r] : -1, (r < q_idx.size()) ? q_dat[r] : '0,
                 r, (r == NR - 1), RL + 1 + r);
      end
    end
    n_cmp++;
    if (done_k != RL + NR + 1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_done: got k=%0d cnt=%0d want k=%0d cnt=1", done_k, done_cnt, RL + NR + 1);
    end
    n_cmp++;
    if (busy_at_done !== 1'b0 || en_at_done !== 1'b1 || busy_low != 0) begin
      n_fail++;
      $display("FAIL basic_busy: got busy@done=%b en@done=%b busy_low=%0d want 0 1 0",
               busy_at_done, en_at_done, busy_low);
    end
  endtask

  task automatic test_backpressure();
    collect(100, 20, -1, -1, 0, 0, 400);
    n_cmp++;
    if (stall_iss != FD) begin
      n_fail++; $display("FAIL bp_issued: got %0d want %0d", stall_iss, FD);
    end
    n_cmp++;
    if (stall_idx != 0 || stall_data !== row_model(0) || hold_viol != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got idx=%0d data=%h viol=%0d want idx=0 data=%h viol=0",
               stall_idx, stall_data, hold_viol, row_model(0));
    end
    n_cmp++;
    if (max_out > FD) begin n_fail++; $display("FAIL bp_credit: got %0d want <=%0d", max_out, FD); end
    n_cmp++;
    if (q_idx.size() != NR || done_cnt != 1 || timed_out) begin
      n_fail++;
      $display("FAIL bp_count: got rows=%0d done=%0d to=%b want %0d 1 0",
               q_idx.size(), done_cnt, timed_out, NR);
    end
    for (int r = 0; r < NR && r < q_idx.size(); r++) begin
      n_cmp++;
      if (q_idx[r] != r || q_dat[r] !== row_model(r)) begin
        n_fail++; $display("FAIL bp_row%0d: got idx=%0d data=%h want idx=%0d", r, q_idx[r], q_dat[r], r);
      end
    end
  endtask

  task automatic test_random_ready();
    collect(30, 0, -1, -1, 0, 0, 2000);
    n_cmp++;
    if (q_idx.size() != NR || done_cnt != 1 || timed_out) begin
      n_fail++;
      $display("FAIL rnd_count: got rows=%0d done=%0d to=%b want %0d 1 0",
               q_idx.size(), done_cnt, timed_out, NR);
    end
    n_cmp++;
    if (max_out > FD || hold_viol != 0) begin
      n_fail++; $display("FAIL rnd_credit: got max=%0d viol=%0d want <=%0d 0", max_out, hold_viol, FD);
    end
    for (int r = 0; r < NR && r < q_idx.size(); r++) begin
      n_cmp++;
      if (q_idx[r] != r || q_dat[r] !== row_model(r) || q_last[r] !== (r == NR - 1)) begin
        n_fail++;
        $display("FAIL rnd_row%0d: got idx=%0d last=%b data=%h want idx=%0d", r, q_idx[r], q_last[r],
                 q_dat[r], r);
      end
    end
  endtask

  task automatic test_ignored_start();
    collect(100, 0, 3, 10, 0, 0, 400);
    n_cmp++;
    if (q_idx.size() != NR || iss.size() != NR || done_cnt != 1) begin
      n_fail++;
      $display("FAIL ign_count: got rows=%0d issues=%0d done=%0d want %0d %0d 1",
               q_idx.size(), iss.size(), done_cnt, NR, NR);
    end
    for (int r = 0; r < NR && r < q_idx.size(); r++) begin
      n_cmp++;
      if (q_idx[r] != r || q_k[r] != RL + 1 + r) begin
        n_fail++; $display("FAIL ign_row%0d: got idx=%0d k=%0d want %0d %0d", r, q_idx[r], q_k[r], r, RL + 1 + r);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    collect(70, 0, -1, -1, 11, 0, 500);
    n_cmp++;
    if (q_idx.size() != 11 || q_idx[10] != 10) begin
      n_fail++; $display("FAIL mid_prefix: got rows=%0d want 11 ending at 10", q_idx.size());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, enable_reading_from_mem, addr_valid_dbg, m_valid, m_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ctrl: got %b want 000000",
               {busy, done, enable_reading_from_mem, addr_valid_dbg, m_valid, m_last});
    end
    n_cmp++;
    if (addr_pi !== '0 || m_row_idx !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_data: got addr=%h idx=%h data=%h want 0", addr_pi, m_row_idx, m_data);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || m_valid || busy || addr_valid_dbg) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_flushed: got %0d active cycles want 0", seen); end
    collect(100, 0, -1, -1, 0, 0, 400);
    n_cmp++;
    if (q_idx.size() != NR || done_cnt != 1 || first_valid_k != RL + 1) begin
      n_fail++;
      $display("FAIL mid_restart: got rows=%0d done=%0d first=%0d want %0d 1 %0d",
               q_idx.size(), done_cnt, first_valid_k, NR, RL + 1);
    end
    for (int r = 0; r < NR && r < q_idx.size(); r++) begin
      n_cmp++;
      if (q_idx[r] != r || q_dat[r] !== row_model(r)) begin
        n_fail++; $display("FAIL mid_row%0d: got idx=%0d data=%h want idx=%0d", r, q_idx[r], q_dat[r], r);
      end
    end
  endtask

  task automatic test_back_to_back();
    collect(100, 0, -1, -1, 0, 1, 400);
    n_cmp++;
    if (post_busy !== 1'b0 || post_issue !== 1'b0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_done_start: got busy=%b issue=%b done=%0d want 0 0 1",
               post_busy, post_issue, done_cnt);
    end
    // Next drain is requested in the cycle right after DONE.
    collect(100, 0, -1, -1, 0, 0, 400);
    n_cmp++;
    if (iss.size() < 1 || iss[0] != 0 || first_valid_k != RL + 1 || q_idx.size() != NR) begin
      n_fail++;
      $display("FAIL b2b_fresh: got first_addr=%0d first_valid=%0d rows=%0d want 0 %0d %0d",
               (iss.size() > 0) ? iss[0] : -1, first_valid_k, q_idx.size(), RL + 1, NR);
    end
  endtask

  task automatic test_wrap_boundary();
    int extra;
    collect(100, 0, -1, -1, 0, 0, 400);
    n_cmp++;
    if (iss.size() != NR || timed_out) begin
      n_fail++; $display("FAIL wrap_issues: got %0d to=%b want %0d 0", iss.size(), timed_out, NR);
    end
    for (int i = 0; i < NR && i < iss.size(); i++) begin
      n_cmp++;
      if (iss[i] != i) begin n_fail++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, iss[i], i); end
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (addr_valid_dbg || busy || m_valid) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_fail++; $display("FAIL wrap_idle: got %0d active cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_ignored_start();
    test_reset_mid_drain();
    test_back_to_back();
    test_wrap_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
